tx_arb_ctrl_module: RTL and testbench

//  UART TX controller/arbiter: shares one serial TX line between two byte requesters.

---
 rtl/tx_arb_ctrl_module_pkg.sv | 17 +
 rtl/tx_arb_ctrl_module_bps_tick.sv | 34 +++
 rtl/tx_arb_ctrl_module.sv | 137 +++++++++++++
 tb/tb_tx_arb_ctrl_module.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_ctrl_module_pkg.sv
// Shared definitions for the two-requester UART TX arbiter.
//   tx_state_t    : frame FSM encoding (IDLE, START, DATA, STOP)
//   BPS_T_DEFAULT : clocks per bit for 9600 baud from a 50 MHz clock
//   BIT_COUNT     : data bits per frame (8N1)
package tx_arb_ctrl_module_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [12:0] BPS_T_DEFAULT = 13'd5208;
    localparam logic [3:0]  BIT_COUNT     = 4'd8;

endpackage

// File: rtl/tx_arb_ctrl_module_bps_tick.sv
// Baud tick generator for the TX arbiter.
// Ports:
//   CLK     in  system clock
//   Rst     in  asynchronous active-high reset
//   En      in  count while high; counter held at zero while low
//   Bit_End out high during the last clock of each bit period (cnt == BPS_T-1)
module tx_bps_tick_module
    import tx_arb_ctrl_module_pkg::*;
#(
    parameter logic [12:0] BPS_T = BPS_T_DEFAULT
) (
    input  logic CLK,
    input  logic Rst,
    input  logic En,
    output logic Bit_End
);

    logic [12:0] cnt;

    assign Bit_End = En && (cnt == BPS_T - 13'd1);

    // Wrapping on Bit_End doubles as the "clear on state entry": every state
    // change of the frame FSM happens on a Bit_End, or from IDLE where En=0.
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            cnt <= 13'd0;
        end else if (!En || Bit_End) begin
            cnt <= 13'd0;
        end else begin
            cnt <= cnt + 13'd1;
        end
    end

endmodule

// File: rtl/tx_arb_ctrl_module.sv
// UART TX controller/arbiter: two byte requesters share one 8N1 serial line.
// Round-robin grant on ties, latched byte, LSB-first framing, all outputs
// registered.
// Ports:
//   CLK, Rst            clock, asynchronous active-high reset
//   Req0/Data0/Ack0     requester 0: level request, byte, 1-cycle latch pulse
//   Req1/Data1/Ack1     requester 1: same rules
//   TX_Pin_Out          serial line, idle high
//   Busy                1 while a frame is in progress
//   Grant               requester of the current/last frame
//   Done                1-cycle pulse when the stop bit completes
//   Dbg_State           current frame FSM state
// Handshake: a requester holds ReqN high with DataN stable until it sees AckN;
// AckN is asserted for exactly one cycle in the cycle DataN has been latched,
// after which Req and Data may change freely.
module tx_arb_ctrl_module
    import tx_arb_ctrl_module_pkg::*;
#(
    parameter logic [12:0] BPS_T = BPS_T_DEFAULT
) (
    input  logic       CLK,
    input  logic       Rst,
    input  logic       Req0,
    input  logic [7:0] Data0,
    output logic       Ack0,
    input  logic       Req1,
    input  logic [7:0] Data1,
    output logic       Ack1,
    output logic       TX_Pin_Out,
    output logic       Busy,
    output logic       Grant,
    output logic       Done,
    output tx_state_t  Dbg_State
);

    tx_state_t  state, state_nxt;
    logic [7:0] shift, shift_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       tx_nxt, busy_nxt, grant_nxt, ack0_nxt, ack1_nxt, done_nxt;
    logic       bit_end;
    logic       pick;

    localparam logic [2:0] LAST_BIT = 3'(BIT_COUNT - 4'd1);

    tx_bps_tick_module #(.BPS_T(BPS_T)) u_tick (
        .CLK     (CLK),
        .Rst     (Rst),
        .En      (state != IDLE),
        .Bit_End (bit_end)
    );

    // On a tie, serve the requester that did not own the previous frame.
    assign pick = (Req0 && Req1) ? ~Grant : Req1;

    assign Dbg_State = state;

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        tx_nxt      = TX_Pin_Out;
        busy_nxt    = Busy;
        grant_nxt   = Grant;
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (Req0 || Req1) begin
                    state_nxt   = START;
                    grant_nxt   = pick;
                    shift_nxt   = pick ? Data1 : Data0;
                    bit_cnt_nxt = 3'd0;
                    tx_nxt      = 1'b0;
                    busy_nxt    = 1'b1;
                    ack0_nxt    = ~pick;
                    ack1_nxt    = pick;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        // shift[1] is the bit that lands in shift[0] this edge
                        shift_nxt   = {1'b0, shift[7:1]};
                        tx_nxt      = shift[1];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant resets to 1 so the first tie after reset goes to requester 0.
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            shift      <= 8'd0;
            bit_cnt    <= 3'd0;
            TX_Pin_Out <= 1'b1;
            Busy       <= 1'b0;
            Grant      <= 1'b1;
            Ack0       <= 1'b0;
            Ack1       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift      <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            TX_Pin_Out <= tx_nxt;
            Busy       <= busy_nxt;
            Grant      <= grant_nxt;
            Ack0       <= ack0_nxt;
            Ack1       <= ack1_nxt;
            Done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_tx_arb_ctrl_module.sv
// Bench for tx_arb_ctrl_module: frame-level reference model, per-cycle compare,
// line receiver with expected-byte queue, directed cases and random traffic.
module tb_tx_arb_ctrl_module;
    import tx_arb_ctrl_module_pkg::*;

    localparam int B = 16;
    localparam int BS = 5208;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = 8'd0, data1 = 8'd0;
    logic       ack0, ack1, tx, busy, grant, done;
    tx_state_t  dbg_state;

    logic       rst_s = 1'b1;
    logic       req0_s = 1'b0, req1_s = 1'b0;
    logic [7:0] data0_s = 8'd0, data1_s = 8'd0;
    logic       ack0_s, ack1_s, tx_s, busy_s, grant_s, done_s;
    tx_state_t  dbg_state_s;

    tx_arb_ctrl_module #(.BPS_T(13'd16)) dut (
        .CLK(clk), .Rst(rst),
        .Req0(req0), .Data0(data0), .Ack0(ack0),
        .Req1(req1), .Data1(data1), .Ack1(ack1),
        .TX_Pin_Out(tx), .Busy(busy), .Grant(grant), .Done(done),
        .Dbg_State(dbg_state)
    );

    tx_arb_ctrl_module dut_slow (
        .CLK(clk), .Rst(rst_s),
        .Req0(req0_s), .Data0(data0_s), .Ack0(ack0_s),
        .Req1(req1_s), .Data1(data1_s), .Ack1(ack1_s),
        .TX_Pin_Out(tx_s), .Busy(busy_s), .Grant(grant_s), .Done(done_s),
        .Dbg_State(dbg_state_s)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit slow_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    // A frame is just "who, which byte, how many cycles since TX fell".
    bit         m_active = 1'b0;
    int         m_k = 0;
    bit         m_grant = 1'b1;
    bit         m_who = 1'b0;
    logic [7:0] m_byte = 8'd0;
    bit         m_ack0 = 1'b0, m_ack1 = 1'b0, m_done = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_k = 0; m_grant = 1'b1;
            m_ack0 = 1'b0; m_ack1 = 1'b0; m_done = 1'b0;
            exp_q.delete();
        end else begin
            m_ack0 = 1'b0; m_ack1 = 1'b0; m_done = 1'b0;
            if (m_active) begin
                m_k++;
                if (m_k == 10 * B) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end
            end else if (req0 || req1) begin
                m_who = (req0 && req1) ? !m_grant : req1;
                m_grant = m_who;
                m_byte = m_who ? data1 : data0;
                exp_q.push_back(m_byte);
                m_active = 1'b1;
                m_k = 0;
                if (m_who) m_ack1 = 1'b1; else m_ack0 = 1'b1;
            end
        end
    end

    function automatic logic m_tx();
        if (!m_active) return 1'b1;
        if (m_k < B) return 1'b0;
        if (m_k >= 9 * B) return 1'b1;
        return m_byte[(m_k - B) / B];
    endfunction

    function automatic logic [1:0] m_state();
        if (!m_active) return 2'd0;
        if (m_k < B) return 2'd1;
        if (m_k < 9 * B) return 2'd2;
        return 2'd3;
    endfunction

    // ---------------- per-cycle compare + line receiver ----------------
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'd0;

    always @(negedge clk) begin
        check("tx", tx, m_tx());
        check("busy", busy, m_active);
        check("grant", grant, m_grant);
        check("ack0", ack0, m_ack0);
        check("ack1", ack1, m_ack1);
        check("done", done, m_done);
        check("state", dbg_state, m_state());

        if (rst) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= B && rx_cnt < 9 * B && (rx_cnt % B) == B / 2)
                rx_byte[(rx_cnt - B) / B] = tx;
            if (rx_cnt == 10 * B) rx_busy = 1'b0;
        end
        if (m_done) begin
            if (exp_q.size() == 0) check("rx_queue_empty", 0, 1);
            else check("rx_byte", rx_byte, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        #2 rst = 1'b1;
        tick(2);
        #2 rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (!(ack0 === 1'b1 || ack1 === 1'b1) && n < 400) begin
            n++;
            tick(1);
        end
        if (n >= 400) check({name, "_ack_timeout"}, 0, 1);
    endtask

    // ---------------- main sequence ----------------
    bit exp1[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        int n;
        int last;
        tick(2);
        #2 rst = 1'b0;
        tick(2);
        check("rst_tx", tx, 1); check("rst_busy", busy, 0); check("rst_grant", grant, 1);
        check("rst_ack0", ack0, 0); check("rst_ack1", ack1, 0); check("rst_done", done, 0);

        // 1: single request, 0xA5
        req0 = 1'b1; data0 = 8'hA5;
        tick(1);
        check("t1_ack0", ack0, 1); check("t1_tx_fall", tx, 0);
        req0 = 1'b0; data0 = 8'($urandom);
        tick(8);
        for (int i = 0; i < 10; i++) begin
            check("t1_bit", tx, exp1[i]);
            if (i < 9) tick(16);
        end
        tick(8);
        check("t1_done", done, 1); check("t1_grant", grant, 0); check("t1_busy", busy, 0);

        // 2: simultaneous requests after reset
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h55; data1 = 8'h0F;
        tick(1);
        check("t2_ack0", ack0, 1); check("t2_ack1_wait", ack1, 0);
        req0 = 1'b0;
        tick(160);
        check("t2_done", done, 1); check("t2_ack1_not_yet", ack1, 0);
        tick(1);
        check("t2_ack1", ack1, 1); check("t2_tx_fall", tx, 0); check("t2_grant", grant, 1);
        req1 = 1'b0; data1 = 8'($urandom);
        tick(24);
        check("t2_bit0", tx, 1);
        tick(64);
        check("t2_bit4", tx, 0);
        tick(80);
        check("t2_idle", busy, 0);

        // 3: both held continuously -> 0,1,0,1 with 161-cycle spacing
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h3C; data1 = 8'hC3;
        last = 0;
        for (int j = 0; j < 4; j++) begin
            wait_ack("t3");
            check("t3_order", ack1, j % 2);
            check("t3_grant", grant, j % 2);
            if (j > 0) check("t3_period", cyc - last, 161);
            last = cyc;
            tick(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(170);

        // 5: Req1 rises in the Done cycle
        req0 = 1'b1; data0 = 8'h00;
        wait_ack("t5");
        check("t5_ack0", ack0, 1);
        req0 = 1'b0;
        tick(143);
        check("t5_bit7", tx, 0);
        n = 0;
        tick(1);
        while (tx === 1'b1 && n < 40) begin
            if (done === 1'b1) begin
                req1 = 1'b1; data1 = 8'hC3;
            end
            n++;
            tick(1);
        end
        check("t5_high_len", n, 17);
        check("t5_ack1", ack1, 1);
        check("t5_tx_fall", tx, 0);

        // 4: reset in DATA bit 3, Req1 held through and after reset
        tick(72);
        #2 rst = 1'b1;
        #1;
        check("t4_async_tx", tx, 1); check("t4_async_busy", busy, 0);
        check("t4_async_done", done, 0); check("t4_async_state", dbg_state, 0);
        tick(2);
        #2 rst = 1'b0;
        tick(1);
        check("t4_ack1", ack1, 1); check("t4_tx_fall", tx, 0);
        req1 = 1'b0;
        n = 0;
        while (tx === 1'b0 && n < 40) begin
            n++;
            tick(1);
        end
        check("t4_start_len", n, 16);
        tick(200);

        // random traffic
        for (int c = 0; c < 6000; c++) begin
            if (req0 && m_ack0) begin
                req0 = 1'($urandom_range(0, 1)); data0 = 8'($urandom);
            end else if (!req0) begin
                if ($urandom_range(0, 7) == 0) begin
                    req0 = 1'b1; data0 = 8'($urandom);
                end
            end else if ($urandom_range(0, 199) == 0) begin
                req0 = 1'b0;
            end
            if (req1 && m_ack1) begin
                req1 = 1'($urandom_range(0, 1)); data1 = 8'($urandom);
            end else if (!req1) begin
                if ($urandom_range(0, 7) == 0) begin
                    req1 = 1'b1; data1 = 8'($urandom);
                end
            end else if ($urandom_range(0, 199) == 0) begin
                req1 = 1'b0;
            end
            tick(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(200);

        n = 0;
        while (!slow_done && n < 60000) begin
            n++;
            tick(1);
        end
        if (!slow_done) check("t6_timeout", 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // 6: default baud, byte 0x00
    initial begin
        int n;
        tick(2);
        #2 rst_s = 1'b0;
        tick(2);
        req0_s = 1'b1; data0_s = 8'h00;
        tick(1);
        check("t6_ack0", ack0_s, 1); check("t6_tx_fall", tx_s, 0);
        req0_s = 1'b0;
        n = 0;
        while (tx_s === 1'b0 && n < 60000) begin
            n++;
            tick(1);
        end
        check("t6_low_len", n, 9 * BS);
        while (done_s !== 1'b1 && n < 60000) begin
            n++;
            tick(1);
        end
        check("t6_done_at", n, 10 * BS);
        check("t6_grant", grant_s, 0);
        slow_done = 1'b1;
    end

endmodule
